magia_l2_port_arbiter: RTL and testbench
========================================

Name: magia_l2_port_arbiter

Overview:
- Shares one L2 memory slave port between the N_TILES_Y west-edge mesh request channels, one per tile row.
- Arbitrates requests round-robin with grant lock.
- Records the granted port of every accepted request in an in-order FIFO, and uses it to steer each L2 response back to its originating row.
- Sits between the mesh's L2 edge ports and the L2 memory model or controller in the testbench and SoC top.

Parameters:
N_PORTS, 4, number of requesting row ports (= magia_pkg::N_TILES_Y)
ADDR_W, 32, request address width
DATA_W, 32, data width; byte enables are DATA_W/8 wide
MAX_OUTST, 8, depth of the outstanding-order FIFO (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  N_PORTS  per-port request valid
req_ready_o  out  N_PORTS  per-port request ready
req_addr_i  in  N_PORTS*ADDR_W  per-port address
req_we_i  in  N_PORTS  per-port write enable
req_be_i  in  N_PORTS*DATA_W/8  per-port byte enables
req_wdata_i  in  N_PORTS*DATA_W  per-port write data
rsp_valid_o  out  N_PORTS  per-port response valid
rsp_ready_i  in  N_PORTS  per-port response ready
rsp_rdata_o  out  DATA_W  response data, broadcast to all ports
rsp_err_o  out  1  response error, broadcast to all ports
l2_req_valid_o  out  1  L2 request valid
l2_req_ready_i  in  1  L2 request ready
l2_req_addr_o / l2_req_we_o / l2_req_be_o / l2_req_wdata_o  out  ADDR_W/1/DATA_W/8/DATA_W  muxed request payload
l2_rsp_valid_i  in  1  L2 response valid; responses return in request order
l2_rsp_ready_o  out  1  L2 response ready
l2_rsp_rdata_i  in  DATA_W  L2 read data
l2_rsp_err_i  in  1  L2 error
unexp_rsp_o  out  1  sticky flag: response arrived with no outstanding request

Behaviour:
- Clocking and reset: single clock domain; clk_i with synchronous active-high rst_i.
- Reset state: FIFO empty, round-robin pointer = 0, lock cleared, unexp_rsp_o = 0. All valid and ready outputs = 0; payload outputs = 0.
- Reset asserted mid-transaction:
  - In-flight tracking is discarded.
  - The L2 model must also be reset.
  - Responses arriving after reset release with an empty FIFO set unexp_rsp_o.
- Arbitration, unlocked cycle: grant goes to the first port with req_valid_i, searching from the pointer upward and wrapping at N_PORTS-1 to 0.
- Request path:
  - l2_req_valid_o = (some port valid) & ~fifo_full.
  - Payload is muxed from the granted port, combinationally, with zero added latency.
  - req_ready_o[g] = l2_req_ready_i & ~fifo_full; all other ready bits are 0.
- Lock: if l2_req_valid_o = 1 and l2_req_ready_i = 0, the grant is registered as locked. The same port stays granted until its handshake completes, so the payload is stable while valid.
- Handshake (l2_req_valid_o & l2_req_ready_i):
  - Push granted index into the FIFO.
  - Pointer becomes g+1 mod N_PORTS.
  - Lock clears.
- FIFO full: no request is offered, even if a pop occurs in the same cycle (push-when-full is never allowed). The pointer and lock are held.
- Response path, FIFO non-empty:
  - h = FIFO head.
  - rsp_valid_o[h] = l2_rsp_valid_i; all other rsp_valid_o bits are 0.
  - l2_rsp_ready_o = rsp_ready_i[h].
  - rsp_rdata_o / rsp_err_o pass through from L2 unregistered.
  - Pop on the response handshake.
- Response path, FIFO empty:
  - l2_rsp_ready_o = 1; the response is dropped.
  - No rsp_valid_o bit is asserted.
  - unexp_rsp_o is set and stays set until reset.
- Same-cycle push and pop are legal whenever not full; occupancy is unchanged.
- A request and its response may not complete in the same cycle: the L2 has at least 1 cycle of latency.
- FIFO pointers are log2(MAX_OUTST) bits wide and wrap naturally. The count is log2(MAX_OUTST)+1 bits wide.

Optional Feature:
- Macro: MAGIA_L2_ARB_STATS_EN.
- When defined, the block adds:
  - Output grant_cnt_o [N_PORTS*32]: per-port count of completed request handshakes.
  - Output stall_cnt_o [32]: cycles where l2_req_valid_o = 1 & l2_req_ready_i = 0, plus cycles where a request is blocked by fifo_full.
  - All counters reset to 0 and saturate at 2^32-1.
- When not defined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Put in magia_pkg:
  - Typedef l2_req_t {addr, we, be, wdata}.
  - Typedef l2_rsp_t {rdata, err}.
  - Localparam L2_ARB_MAX_OUTST = 8.
- One sub-module: magia_l2_order_fifo. It is a parametric-depth FIFO of $clog2(N_PORTS)-bit indices with push/pop/full/empty/head. The top module holds the round-robin logic, the lock, and the steering.

Test Plan:
- Single port: port 2 issues a write to 0x1C00_0010 followed by a read of the same address. Required: both forwarded unchanged; read rsp_valid_o = 4'b0100 with data = written value; unexp_rsp_o = 0.
- Round-robin fairness: all 4 ports hold valid continuously and l2_req_ready_i = 1. Required: grant sequence 0,1,2,3,0,1,… and each port receives 25 of 100 grants.
- Lock: port 1 is granted while l2_req_ready_i = 0 for 5 cycles and port 0 asserts valid during the stall. Required: payload holds port 1 for all 5 cycles; port 0 is served next after port 1's handshake.
- FIFO full: MAX_OUTST=8 requests accepted with L2 withholding responses. Required: the 9th request sees l2_req_valid_o = 0 and req_ready_o = 0. After one response is popped, the 9th request is accepted on the following cycle.
- Response backpressure and order: responses for ports 3,0,3. While rsp_ready_i[3] = 0, l2_rsp_ready_o must stay 0; then the responses are delivered strictly in order to ports 3, 0, 3.
- Unexpected response and reset: l2_rsp_valid_i = 1 with the FIFO empty. Required: l2_rsp_ready_o = 1, no rsp_valid_o bit asserted, unexp_rsp_o = 1 until rst_i, which clears it. With MAGIA_L2_ARB_STATS_EN defined, the counters also read 0 after rst_i.

Source files
------------

// File: rtl/magia_pkg.sv
// Shared MAGIA constants and L2 edge types used by the mesh-to-L2 glue logic.
package magia_pkg;

    localparam int N_TILES_Y        = 4;
    localparam int L2_ADDR_W        = 32;
    localparam int L2_DATA_W        = 32;
    localparam int L2_ARB_MAX_OUTST = 8;

    typedef struct packed {
        logic [L2_ADDR_W-1:0]   addr;
        logic                   we;
        logic [L2_DATA_W/8-1:0] be;
        logic [L2_DATA_W-1:0]   wdata;
    } l2_req_t;

    typedef struct packed {
        logic [L2_DATA_W-1:0] rdata;
        logic                 err;
    } l2_rsp_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/magia_l2_order_fifo.sv
// In-order FIFO of granted port indices; the head names the row owed the next L2 response.
module magia_l2_order_fifo #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [IDX_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_idx;
        end
    end

    assign full  = count_q[PTR_W];
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/magia_l2_port_arbiter.sv
// Shares one L2 slave port among the west-edge row channels: round-robin with grant lock, in-order response steering.
// Optional per-port grant and stall counters are built when MAGIA_L2_ARB_STATS_EN is defined.
module magia_l2_port_arbiter
    import magia_pkg::*;
#(
    parameter int N_PORTS   = N_TILES_Y,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = L2_ARB_MAX_OUTST
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_PORTS-1:0]         req_valid_i,
    output logic [N_PORTS-1:0]         req_ready_o,
    input  logic [N_PORTS*ADDR_W-1:0]  req_addr_i,
    input  logic [N_PORTS-1:0]         req_we_i,
    input  logic [N_PORTS*DATA_W/8-1:0] req_be_i,
    input  logic [N_PORTS*DATA_W-1:0]  req_wdata_i,
    output logic [N_PORTS-1:0]         rsp_valid_o,
    input  logic [N_PORTS-1:0]         rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic                       l2_req_valid_o,
    input  logic                       l2_req_ready_i,
    output logic [ADDR_W-1:0]          l2_req_addr_o,
    output logic                       l2_req_we_o,
    output logic [DATA_W/8-1:0]        l2_req_be_o,
    output logic [DATA_W-1:0]          l2_req_wdata_o,
    input  logic                       l2_rsp_valid_i,
    output logic                       l2_rsp_ready_o,
    input  logic [DATA_W-1:0]          l2_rsp_rdata_i,
    input  logic                       l2_rsp_err_i,
    output logic                       unexp_rsp_o
`ifdef MAGIA_L2_ARB_STATS_EN
    ,
    output logic [N_PORTS*32-1:0]      grant_cnt_o,
    output logic [31:0]                stall_cnt_o
`endif
);

    // state      | meaning
    // ARB_OPEN   | grant follows the round-robin search from rr_ptr_q
    // ARB_LOCKED | offered request stalled; grant pinned to lock_idx_q until its handshake

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int BE_W  = DATA_W / 8;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] grant;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] head;
    logic             any_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             l2_valid;
    logic             req_hs;
    logic             rsp_hs;
    logic             unexp_q;

    assign any_valid = |req_valid_i;

    // Walk offsets from the highest down so the smallest offset with a valid request wins.
    always_comb begin
        rr_idx = rr_ptr_q;
        cand   = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_PORTS)) begin
                cand = cand - (IDX_W+1)'(N_PORTS);
            end
            if (req_valid_i[cand[IDX_W-1:0]]) begin
                rr_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign grant    = (state_q == ARB_LOCKED) ? lock_idx_q : rr_idx;
    assign l2_valid = any_valid & ~fifo_full & ~rst_i;
    assign req_hs   = l2_valid & l2_req_ready_i;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ARB_OPEN: begin
                if (l2_valid && !l2_req_ready_i) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = grant;
                end
            end
            ARB_LOCKED: begin
                if (req_hs) begin
                    state_d = ARB_OPEN;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
        if (req_hs) begin
            rr_ptr_d = (grant == IDX_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_OPEN;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            unexp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            unexp_q    <= unexp_q | (l2_rsp_valid_i & fifo_empty);
        end
    end

    always_comb begin
        l2_req_valid_o = l2_valid;
        req_ready_o    = '0;
        l2_req_addr_o  = '0;
        l2_req_we_o    = 1'b0;
        l2_req_be_o    = '0;
        l2_req_wdata_o = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (l2_valid && (grant == IDX_W'(i))) begin
                req_ready_o[i] = l2_req_ready_i;
                l2_req_addr_o  = req_addr_i[i*ADDR_W +: ADDR_W];
                l2_req_we_o    = req_we_i[i];
                l2_req_be_o    = req_be_i[i*BE_W +: BE_W];
                l2_req_wdata_o = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // With nothing outstanding the response is swallowed so the L2 can never wedge.
    always_comb begin
        rsp_valid_o    = '0;
        l2_rsp_ready_o = 1'b0;
        if (!rst_i) begin
            if (fifo_empty) begin
                l2_rsp_ready_o = 1'b1;
            end else begin
                rsp_valid_o[head] = l2_rsp_valid_i;
                l2_rsp_ready_o    = rsp_ready_i[head];
            end
        end
    end

    assign rsp_hs      = l2_rsp_valid_i & l2_rsp_ready_o & ~fifo_empty;
    assign rsp_rdata_o = l2_rsp_rdata_i;
    assign rsp_err_o   = l2_rsp_err_i;
    assign unexp_rsp_o = unexp_q;

    magia_l2_order_fifo #(
        .DEPTH (MAX_OUTST),
        .IDX_W (IDX_W)
    ) u_order_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (req_hs),
        .push_idx (grant),
        .pop      (rsp_hs),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

`ifdef MAGIA_L2_ARB_STATS_EN
    logic [31:0] grant_cnt_q [N_PORTS];
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = (l2_valid & ~l2_req_ready_i) | (any_valid & fifo_full & ~rst_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_PORTS; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (req_hs && (grant == IDX_W'(i)) && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
                end
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt_out
        assign grant_cnt_o[g*32 +: 32] = grant_cnt_q[g];
    end
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_magia_l2_port_arbiter.sv
// Self-checking bench for magia_l2_port_arbiter: directed scenarios plus a randomized phase
// checked against a queue-based reference of arbitration, ordering and an L2 memory.
module tb_magia_l2_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*BW-1:0]   req_be;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              l2_req_valid, l2_req_ready, l2_req_we;
    logic [AW-1:0]     l2_req_addr;
    logic [BW-1:0]     l2_req_be;
    logic [DW-1:0]     l2_req_wdata;
    logic              l2_rsp_valid, l2_rsp_ready, l2_rsp_err;
    logic [DW-1:0]     l2_rsp_rdata;
    logic              unexp;
`ifdef MAGIA_L2_ARB_STATS_EN
    logic [N*32-1:0]   grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    magia_l2_port_arbiter #(
        .N_PORTS   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_OUTST (MO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_be_i       (req_be),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .l2_req_valid_o (l2_req_valid),
        .l2_req_ready_i (l2_req_ready),
        .l2_req_addr_o  (l2_req_addr),
        .l2_req_we_o    (l2_req_we),
        .l2_req_be_o    (l2_req_be),
        .l2_req_wdata_o (l2_req_wdata),
        .l2_rsp_valid_i (l2_rsp_valid),
        .l2_rsp_ready_o (l2_rsp_ready),
        .l2_rsp_rdata_i (l2_rsp_rdata),
        .l2_rsp_err_i   (l2_rsp_err),
        .unexp_rsp_o    (unexp)
`ifdef MAGIA_L2_ARB_STATS_EN
        ,
        .grant_cnt_o    (grant_cnt),
        .stall_cnt_o    (stall_cnt)
`endif
    );

    typedef struct {
        bit          v;
        bit [AW-1:0] addr;
        bit          we;
        bit [BW-1:0] be;
        bit [DW-1:0] wdata;
    } preq_t;

    typedef struct {
        int          port;
        bit [DW-1:0] rdata;
        bit          err;
        int          rdy_cyc;
    } ent_t;

    // Reference state: pending row requests, outstanding responses in order, L2 memory contents.
    preq_t       pend [N];
    ent_t        exp_q [$];
    bit [DW-1:0] mem [bit [AW-1:0]];
    int          rr_start;
    int          lock_port;
    bit          exp_unexp;
    int          grant_log [$];
    int          deliv_port [$];
    bit [DW-1:0] deliv_data [$];
    bit [N-1:0]  last_rsp_vec;
    int          m_grant [N];
    int          m_stall;
    int          cyc;

    int          spawn_pct;
    int          req_rdy_mode;
    int          rsp_budget;
    bit [N-1:0]  rsp_rdy_mask;
    bit          rand_rsp;
    bit          force_unexp;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef MAGIA_L2_ARB_STATS_EN
        for (int p = 0; p < N; p++) begin
            chk("grant_cnt", grant_cnt[p*32 +: 32], m_grant[p]);
        end
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic new_req(input int p);
        pend[p].v     = 1'b1;
        pend[p].addr  = 32'h1C00_0000 + 32'($urandom_range(0, 15)) * 4;
        pend[p].we    = 1'($urandom_range(0, 1));
        pend[p].be    = 4'($urandom_range(1, 15));
        pend[p].wdata = $urandom;
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (!pend[p].v && ($urandom_range(1, 100) <= spawn_pct)) begin
                new_req(p);
            end
            req_valid[p]             = pend[p].v;
            req_addr[p*AW +: AW]     = pend[p].addr;
            req_we[p]                = pend[p].we;
            req_be[p*BW +: BW]       = pend[p].be;
            req_wdata[p*DW +: DW]    = pend[p].wdata;
        end
        l2_req_ready = (req_rdy_mode == 0) ? 1'b1 :
                       (req_rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        rsp_ready    = rand_rsp ? N'($urandom) : rsp_rdy_mask;
        if (force_unexp) begin
            l2_rsp_valid = 1'b1;
            l2_rsp_rdata = $urandom;
            l2_rsp_err   = 1'b0;
        end else if (exp_q.size() > 0 && exp_q[0].rdy_cyc <= cyc && rsp_budget != 0 &&
                     (!rand_rsp || $urandom_range(0, 3) != 0)) begin
            l2_rsp_valid = 1'b1;
            l2_rsp_rdata = exp_q[0].rdata;
            l2_rsp_err   = exp_q[0].err;
        end else begin
            l2_rsp_valid = 1'b0;
            l2_rsp_rdata = $urandom;
            l2_rsp_err   = 1'b0;
        end
    endtask

    // Evaluate one cycle against the reference, then commit what the coming edge will do.
    task automatic check_cycle();
        int         g;
        int         h;
        bit         full;
        bit         any;
        bit         exp_valid;
        bit [N-1:0] er;
        bit         rsp_rdy_exp;
        ent_t       e;
        bit [DW-1:0] word;

        full = (exp_q.size() == MO);
        g = -1;
        if (lock_port >= 0) begin
            g = lock_port;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && pend[(rr_start + i) % N].v) g = (rr_start + i) % N;
            end
        end
        any       = (g >= 0);
        exp_valid = any && !full;
        er        = '0;
        if (exp_valid && l2_req_ready) er[g] = 1'b1;

        chk("l2_req_valid", l2_req_valid, exp_valid);
        chk("req_ready", req_ready, er);
        if (exp_valid) begin
            chk("l2_req_payload", {l2_req_addr, l2_req_we, l2_req_be, l2_req_wdata},
                {pend[g].addr, pend[g].we, pend[g].be, pend[g].wdata});
        end
        chk("unexp_rsp", unexp, exp_unexp);

        if (exp_q.size() == 0) begin
            chk("rsp_valid_idle", rsp_valid, '0);
            chk("l2_rsp_ready_idle", l2_rsp_ready, 1'b1);
            rsp_rdy_exp = 1'b1;
        end else begin
            h = exp_q[0].port;
            er = '0;
            er[h] = l2_rsp_valid;
            rsp_rdy_exp = rsp_ready[h];
            chk("rsp_valid", rsp_valid, er);
            chk("l2_rsp_ready", l2_rsp_ready, rsp_rdy_exp);
            if (l2_rsp_valid) begin
                chk("rsp_data", {rsp_rdata, rsp_err}, {exp_q[0].rdata, exp_q[0].err});
            end
        end

        if (exp_valid && !l2_req_ready) m_stall++;
        if (any && full) m_stall++;

        if (l2_rsp_valid && rsp_rdy_exp) begin
            if (exp_q.size() == 0) begin
                exp_unexp = 1'b1;
            end else begin
                deliv_port.push_back(exp_q[0].port);
                deliv_data.push_back(exp_q[0].rdata);
                last_rsp_vec = rsp_valid;
                void'(exp_q.pop_front());
                if (rsp_budget > 0) rsp_budget--;
            end
        end

        if (exp_valid && l2_req_ready) begin
            e.port    = g;
            e.rdy_cyc = cyc + 1;
            e.err     = ($urandom_range(0, 7) == 0);
            word      = mem.exists(pend[g].addr) ? mem[pend[g].addr] : '0;
            if (pend[g].we) begin
                for (int b = 0; b < BW; b++) begin
                    if (pend[g].be[b]) word[b*8 +: 8] = pend[g].wdata[b*8 +: 8];
                end
                mem[pend[g].addr] = word;
                e.rdata = '0;
            end else begin
                e.rdata = word;
            end
            exp_q.push_back(e);
            grant_log.push_back(g);
            m_grant[g]++;
            pend[g].v = 1'b0;
            rr_start  = (g + 1) % N;
            lock_port = -1;
        end else if (exp_valid) begin
            lock_port = g;
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        req_valid    = '0;
        req_addr     = '0;
        req_we       = '0;
        req_be       = '0;
        req_wdata    = '0;
        rsp_ready    = '0;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_rdata = '0;
        l2_rsp_err   = 1'b0;
        for (int p = 0; p < N; p++) begin
            pend[p].v  = 1'b0;
            m_grant[p] = 0;
        end
        exp_q.delete();
        mem.delete();
        grant_log.delete();
        deliv_port.delete();
        deliv_data.delete();
        rr_start     = 0;
        lock_port    = -1;
        exp_unexp    = 1'b0;
        m_stall      = 0;
        spawn_pct    = 0;
        req_rdy_mode = 0;
        rsp_budget   = -1;
        rsp_rdy_mask = '1;
        rand_rsp     = 1'b0;
        force_unexp  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_l2_req_valid", l2_req_valid, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_l2_rsp_ready", l2_rsp_ready, 1'b0);
        chk("rst_unexp", unexp, 1'b0);
        chk("rst_payload", {l2_req_addr, l2_req_we, l2_req_be, l2_req_wdata}, '0);
        check_stats();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt [N];
        int bad;
        bit [AW-1:0] a1;
        bit [DW-1:0] wd;

        rst = 1'b1;
        cyc = 0;
        do_reset();

        // Single port: write then read back on row 2.
        wd = $urandom;
        pend[2] = '{v: 1'b1, addr: 32'h1C00_0010, we: 1'b1, be: 4'hF, wdata: wd};
        for (int k = 0; k < 20 && grant_log.size() < 1; k++) step();
        chk("t1_wr_granted", grant_log.size(), 1);
        pend[2] = '{v: 1'b1, addr: 32'h1C00_0010, we: 1'b0, be: 4'hF, wdata: 32'h0};
        for (int k = 0; k < 20 && deliv_port.size() < 2; k++) step();
        chk("t1_rsp_count", deliv_port.size(), 2);
        chk("t1_rd_port", deliv_port[1], 2);
        chk("t1_rd_vec", last_rsp_vec, 4'b0100);
        chk("t1_rd_data", deliv_data[1], wd);
        chk("t1_unexp", unexp, 1'b0);

        // Round-robin fairness with every row requesting continuously.
        do_reset();
        spawn_pct = 100;
        for (int k = 0; k < 200 && grant_log.size() < 100; k++) step();
        chk("t2_grants", grant_log.size() >= 100, 1'b1);
        bad = 0;
        for (int p = 0; p < N; p++) cnt[p] = 0;
        for (int i = 0; i < 100 && i < grant_log.size(); i++) begin
            if (grant_log[i] != i % N) bad++;
            cnt[grant_log[i]]++;
        end
        chk("t2_rr_sequence_errors", bad, 0);
        for (int p = 0; p < N; p++) chk("t2_share", cnt[p], 25);
        check_stats();

        // Lock: row 1 stalls for 5 cycles while row 0 becomes valid.
        do_reset();
        req_rdy_mode = 1;
        new_req(1);
        a1 = pend[1].addr;
        step();
        chk("t3_hold_addr", l2_req_addr, a1);
        new_req(0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_hold_addr", l2_req_addr, a1);
        end
        req_rdy_mode = 0;
        for (int k = 0; k < 10 && grant_log.size() < 2; k++) step();
        chk("t3_first", grant_log.size() > 0 ? grant_log[0] : -1, 1);
        chk("t3_second", grant_log.size() > 1 ? grant_log[1] : -1, 0);
        check_stats();

        // Outstanding-order FIFO full.
        do_reset();
        spawn_pct  = 100;
        rsp_budget = 0;
        for (int k = 0; k < 30 && grant_log.size() < MO; k++) step();
        chk("t4_accepted", grant_log.size(), MO);
        step();
        chk("t4_full_valid", l2_req_valid, 1'b0);
        chk("t4_full_ready", req_ready, '0);
        rsp_budget = 1;
        step();
        chk("t4_pop_cycle_valid", l2_req_valid, 1'b0);
        chk("t4_popped", deliv_port.size(), 1);
        step();
        chk("t4_ninth_valid", l2_req_valid, 1'b1);
        chk("t4_ninth_accepted", grant_log.size(), MO + 1);
        check_stats();

        // Response backpressure and ordering for rows 3, 0, 3.
        do_reset();
        rsp_budget = 0;
        new_req(3);
        for (int k = 0; k < 10 && grant_log.size() < 1; k++) step();
        new_req(0);
        for (int k = 0; k < 10 && grant_log.size() < 2; k++) step();
        new_req(3);
        for (int k = 0; k < 10 && grant_log.size() < 3; k++) step();
        chk("t5_issued", grant_log.size(), 3);
        rsp_budget   = -1;
        rsp_rdy_mask = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_bp_l2_rsp_ready", l2_rsp_ready, 1'b0);
            chk("t5_bp_rsp_valid", rsp_valid, 4'b1000);
        end
        chk("t5_bp_none_delivered", deliv_port.size(), 0);
        rsp_rdy_mask = '1;
        for (int k = 0; k < 20 && deliv_port.size() < 3; k++) step();
        chk("t5_delivered", deliv_port.size(), 3);
        chk("t5_order0", deliv_port.size() > 0 ? deliv_port[0] : -1, 3);
        chk("t5_order1", deliv_port.size() > 1 ? deliv_port[1] : -1, 0);
        chk("t5_order2", deliv_port.size() > 2 ? deliv_port[2] : -1, 3);

        // Unexpected response with an empty FIFO, cleared only by reset.
        do_reset();
        force_unexp = 1'b1;
        step();
        chk("t6_drop_ready", l2_rsp_ready, 1'b1);
        chk("t6_drop_no_valid", rsp_valid, '0);
        force_unexp = 1'b0;
        step();
        chk("t6_unexp_set", unexp, 1'b1);
        repeat (3) step();
        chk("t6_unexp_sticky", unexp, 1'b1);
        do_reset();
        step();
        chk("t6_unexp_cleared", unexp, 1'b0);

        // Randomized traffic, then drain.
        do_reset();
        spawn_pct    = 40;
        req_rdy_mode = 2;
        rand_rsp     = 1'b1;
        repeat (600) step();
        spawn_pct    = 0;
        req_rdy_mode = 0;
        rand_rsp     = 1'b0;
        for (int k = 0; k < 300 && (exp_q.size() > 0 || pend[0].v || pend[1].v || pend[2].v || pend[3].v); k++) step();
        chk("t7_drained", exp_q.size() == 0 && !(pend[0].v || pend[1].v || pend[2].v || pend[3].v), 1'b1);
        chk("t7_unexp", unexp, 1'b0);
        check_stats();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
